// File: rtl/spi_tx_engine.sv
// spi_tx_engine
//   SPI mode-0 master transmit engine. Pops one word at a time from an
//   upstream FIFO, shifts it out MSB first on mosi while shifting miso into
//   an RX register, and reports each completed RX word with a one-cycle
//   rx_valid pulse.
//
//   Optional feature, enabled by defining SPI_BURST_EN: when another word is
//   available at the end of a word, the engine pops it straight away and keeps
//   cs_n low, so consecutive words share one chip-select frame. Without the
//   macro every word gets its own cs_n frame followed by a GAP.
//
// Parameters
//   CLK_DIV  clk cycles per SCLK half-period (2..255)
//   WORD_W   bits per SPI word (matches upstream FIFO width)
//
// Ports
//   clk_i         system clock, rising edge
//   rstn_i        asynchronous active-low reset
//   enable_i      allow words to be popped and sent
//   fifo_empty_i  upstream FIFO empty flag
//   fifo_ren_o    one-cycle pop strobe to the FIFO
//   fifo_rdata_i  FIFO data, valid the cycle after fifo_ren_o
//   sclk_o        SPI clock, idles low
//   mosi_o        serial data out, MSB first
//   miso_i        serial data in
//   cs_n_o        active-low chip select
//   rx_data_o     last fully received word
//   rx_valid_o    one-cycle pulse when rx_data_o updates
//   busy_o        high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for enable and a non-empty FIFO
// POP   | fifo_ren_o asserted, FIFO presents data next cycle
// LOAD  | capture FIFO data, drop cs_n, present MSB on mosi
// SHIFT | 2*WORD_W sclk half-periods of CLK_DIV cycles each
// GAP   | cs_n high for CLK_DIV cycles before returning to IDLE
module spi_tx_engine #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned WORD_W  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              enable_i,
  input  logic              fifo_empty_i,
  output logic              fifo_ren_o,
  input  logic [WORD_W-1:0] fifo_rdata_i,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_n_o,
  output logic [WORD_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HP_W  = $clog2(2 * WORD_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * WORD_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [WORD_W-1:0] tx_sr_q, tx_sr_d;
  logic [WORD_W-1:0] rx_sr_q, rx_sr_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              rx_valid_q, rx_valid_d;

  logic half_end;
  logic last_half;
  logic more_words;

  assign half_end   = (div_q == DIV_LAST);
  assign last_half  = (hp_q == HP_LAST);
  assign more_words = enable_i && !fifo_empty_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      hp_q       <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      hp_q       <= hp_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    hp_d       = hp_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (more_words) state_d = ST_POP;
      end

      ST_POP: begin
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        tx_sr_d = fifo_rdata_i;
        mosi_d  = fifo_rdata_i[WORD_W-1];
        rx_sr_d = '0;
        cs_n_d  = 1'b0;
        sclk_d  = 1'b0;
        div_d   = '0;
        hp_d    = '0;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        div_d = div_q + DIV_W'(1);
        if (half_end) begin
          div_d  = '0;
          hp_d   = hp_q + HP_W'(1);
          sclk_d = ~sclk_q;
          // Even half-periods end on a rising sclk edge, odd ones on a falling edge.
          if (!hp_q[0]) begin
            rx_sr_d = {rx_sr_q[WORD_W-2:0], miso_i};
          end else if (!last_half) begin
            tx_sr_d = {tx_sr_q[WORD_W-2:0], 1'b0};
            mosi_d  = tx_sr_q[WORD_W-2];
          end
          if (last_half) begin
            hp_d       = '0;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
`ifdef SPI_BURST_EN
            if (more_words) begin
              state_d = ST_POP;
            end else begin
              state_d = ST_GAP;
              cs_n_d  = 1'b1;
            end
`else
            state_d = ST_GAP;
            cs_n_d  = 1'b1;
`endif
          end
        end
      end

      ST_GAP: begin
        div_d = div_q + DIV_W'(1);
        if (half_end) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The pop strobe is gated by the empty flag so a FIFO drained by someone
  // else between IDLE and POP is never over-read.
  assign fifo_ren_o = (state_q == ST_POP) && !fifo_empty_i;
  assign busy_o     = (state_q != ST_IDLE);
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign cs_n_o     = cs_n_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule

// File: doc/spi_tx_engine.md
SPI_TX_ENGINE -- requirements
Module: spi_tx_engine

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 Parameter WORD_W, default 16: bits per SPI word; must equal the upstream FIFO data width.
REQ-003 clk  input  1  system clock; every flop is clocked on the rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high allows words to be popped and transmitted.
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_ren  output  1  one-cycle pop strobe to the upstream FIFO.
REQ-008 fifo_rdata  input  WORD_W  FIFO read data, valid on the cycle after the cycle in which fifo_ren is high.
REQ-009 sclk  output  1  SPI clock, mode 0 (idles low).
REQ-010 mosi  output  1  serial data out, MSB first.
REQ-011 miso  input  1  serial data in.
REQ-012 cs_n  output  1  active-low chip select.
REQ-013 rx_data  output  WORD_W  last fully received MISO word.
REQ-014 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-015 busy  output  1  high in every state other than IDLE.

Function
REQ-016 The block SHALL implement the FSM states IDLE, POP, LOAD, SHIFT and GAP.
REQ-017 IDLE->POP SHALL occur when enable=1 and fifo_empty=0; in that cycle fifo_ren=1 for exactly one cycle.
REQ-018 POP->LOAD SHALL be unconditional.
REQ-019 LOAD SHALL capture fifo_rdata into the TX shift register, drive cs_n=0 and mosi=bit WORD_W-1, clear the divider and bit counter, and go to SHIFT.
REQ-020 In SHIFT the divider SHALL count CLK_DIV cycles per half-period.
REQ-021 sclk SHALL toggle at the end of each half-period, giving 2*WORD_W half-periods per word.
REQ-022 miso SHALL be sampled into the RX shift register on every sclk rising edge.
REQ-023 mosi SHALL advance to the next lower bit on every sclk falling edge, except the last falling edge.
REQ-024 After the last (2*WORD_W-th) half-period, sclk SHALL be low, rx_data SHALL be loaded from the RX shift register, and rx_valid SHALL pulse for 1 cycle.
REQ-025 After the last half-period the FSM SHALL enter GAP.
REQ-026 GAP SHALL last CLK_DIV cycles with cs_n=1, then return to IDLE; see REQ-032 for the burst exception.
REQ-027 fifo_ren SHALL never be asserted while fifo_empty=1 or outside the POP state.
REQ-028 Deassertion of enable mid-word SHALL NOT abort the word: the word completes and the FSM then stops in IDLE.
REQ-029 Bit order SHALL be MSB first; miso bits SHALL shift into rx_data LSB side so the first bit received lands in bit WORD_W-1.

Reset
REQ-030 While rstn=0, regardless of state, all of the following SHALL hold immediately:
- state=IDLE
- sclk=0
- cs_n=1
- mosi=0
- fifo_ren=0
- rx_data=0
- rx_valid=0
- busy=0
- divider, bit counter and shift registers cleared
REQ-031 A partially shifted word interrupted by reset SHALL be discarded and not retransmitted after release.

Configuration
REQ-032 When SPI_BURST_EN is defined, at the end of SHIFT with enable=1 and fifo_empty=0, the FSM SHALL go directly to POP instead of GAP.
REQ-033 In that burst case cs_n SHALL stay 0 across POP and LOAD, so consecutive words share one chip-select frame; sclk stays low during POP and LOAD.
REQ-034 When SPI_BURST_EN is not defined, every word SHALL be framed by its own cs_n low period and followed by GAP.

Verification
REQ-035 Single word, CLK_DIV=4: FIFO holds 16'hB232, enable=1 ->
- fifo_ren pulses once.
- cs_n falls 2 cycles later.
- mosi bit sequence 1011001000110010.
- 16 sclk pulses of 8 cycles each.
- busy returns low CLK_DIV cycles after cs_n rises.
REQ-036 Loopback (miso tied to mosi): FIFO words 16'hFFFF, 16'h00FF, 16'h1111 -> rx_valid pulses 3 times with rx_data 16'hFFFF, 16'h00FF, 16'h1111 in order.
REQ-037 Empty FIFO with enable=1 for 100 cycles -> fifo_ren, busy and sclk all stay 0 and cs_n stays 1.
REQ-038 enable dropped at bit 8 of 16'hAAAA with 16'hBBBB queued -> 16'hAAAA completes and 16'hBBBB is not popped.
REQ-039 rstn pulsed low at bit 5 -> all outputs take their reset values asynchronously; the next word after release starts with a fresh POP.
REQ-040 With SPI_BURST_EN, 4 queued words 16'h0017 -> cs_n stays low for all 64 bits and exactly 4 rx_valid pulses occur; without SPI_BURST_EN -> 4 separate cs_n frames.
